// File: rtl/mac_pkg.sv
// Shared types and width helpers for the MAC receive path.
package mac_pkg;

  function automatic int clog_base(input int value, input int base);
    int r;
    longint v;
    r = 0;
    v = 1;
    while (v < longint'(value)) begin
      v = v * base;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int clog2(input int value);
    return clog_base(value, 2);
  endfunction

  // Partial sums are 4*DATA_WIDTH wide; K_TILES of them need clog2(K_TILES) carry bits.
  function automatic int acc_width(input int data_width, input int k_tiles);
    return 4 * data_width + clog2(k_tiles);
  endfunction

  localparam int DEF_ACC_W = 34;
  localparam int DEF_ADDR_I_W = 8;
  localparam int DEF_ADDR_K_W = 8;

  typedef struct packed {
    logic [DEF_ACC_W-1:0]    data;
    logic [DEF_ADDR_I_W-1:0] addr_i;
    logic [DEF_ADDR_K_W-1:0] addr_k;
  } res_entry_t;

endpackage

// File: rtl/mac_result_collector_if.sv
// Completed-result stream: the entry transfers on any cycle where res_val and res_rdy are both 1;
// the source keeps res_data/res_addr_* stable while res_val=1 and res_rdy=0.
interface mac_result_collector_if #(
  parameter int ACC_W = 34,
  parameter int AIW   = 8,
  parameter int AKW   = 8
);
  logic [ACC_W-1:0] res_data;
  logic [AIW-1:0]   res_addr_i;
  logic [AKW-1:0]   res_addr_k;
  logic             res_val;
  logic             res_rdy;

  modport master (output res_data, output res_addr_i, output res_addr_k, output res_val, input res_rdy);
  modport slave  (input res_data, input res_addr_i, input res_addr_k, input res_val, output res_rdy);
endinterface

// File: rtl/mac_result_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module mac_result_fifo
  import mac_pkg::*;
#(
  parameter type entry_t = res_entry_t,
  parameter int  DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  entry_t                push_data,
  input  logic                  pop,
  output entry_t                pop_data,
  output logic [clog2(DEPTH):0] count,
  output logic                  full,
  output logic                  empty
);
  localparam int PW = clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  // Memory is cleared on reset so the output bus reads zero out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/mac_result_collector.sv
// Accumulates K_TILES partial dot products per (i,k) element from the MAC stream and
// queues completed results for a valid/ready consumer.
module mac_result_collector
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDRESS_WIDTH_I = 8,
  parameter int ADDRESS_WIDTH_K = 8,
  parameter int K_TILES         = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int STALL_MARGIN    = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [4*DATA_WIDTH-1:0]    sum_in,
  input  logic [ADDRESS_WIDTH_I-1:0] addr_i_in,
  input  logic [ADDRESS_WIDTH_K-1:0] addr_k_in,
  input  logic                       val_in,
  mac_result_collector_if.master     res,
  output logic                       stall_out,
  output logic                       overflow,
  output logic                       tag_err
);
  localparam int ACC_W = acc_width(DATA_WIDTH, K_TILES);
  localparam int TW    = (K_TILES > 1) ? clog2(K_TILES) : 1;
  localparam int CW    = clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [ACC_W-1:0]           data;
    logic [ADDRESS_WIDTH_I-1:0] addr_i;
    logic [ADDRESS_WIDTH_K-1:0] addr_k;
  } entry_t;

  logic [TW-1:0]              tile_cnt;
  logic [ACC_W-1:0]           acc;
  logic [ADDRESS_WIDTH_I-1:0] tag_i;
  logic [ADDRESS_WIDTH_K-1:0] tag_k;

  logic             mismatch;
  logic             first;
  logic             last;
  logic             push;
  logic             pop;
  logic [ACC_W-1:0] acc_next;
  entry_t           push_data;
  entry_t           head;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;

  // A tag change mid-element abandons the partial and restarts with this beat as tile 0.
  always_comb begin
    mismatch  = (tile_cnt != '0) && ({addr_i_in, addr_k_in} != {tag_i, tag_k});
    first     = (tile_cnt == '0) || mismatch;
    acc_next  = (first ? '0 : acc) + ACC_W'(sum_in);
    last      = first ? (K_TILES == 1) : (tile_cnt == TW'(K_TILES - 1));
    push      = val_in & last;
    push_data = '{data: acc_next, addr_i: addr_i_in, addr_k: addr_k_in};
  end

  assign pop = res.res_val & res.res_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      tile_cnt <= '0;
      acc      <= '0;
      tag_i    <= '0;
      tag_k    <= '0;
      overflow <= 1'b0;
      tag_err  <= 1'b0;
    end else if (val_in) begin
      acc <= acc_next;
      if (first) begin
        tag_i <= addr_i_in;
        tag_k <= addr_k_in;
      end
      if (last)       tile_cnt <= '0;
      else if (first) tile_cnt <= TW'(1);
      else            tile_cnt <= tile_cnt + 1'b1;
      if (mismatch) tag_err <= 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  mac_result_fifo #(
    .entry_t (entry_t),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign res.res_val    = ~empty;
  assign res.res_data   = head.data;
  assign res.res_addr_i = head.addr_i;
  assign res.res_addr_k = head.addr_k;
  assign stall_out      = (FIFO_DEPTH - int'(count)) < STALL_MARGIN;
endmodule

// File: tb/tb_mac_result_collector.sv
// Directed bench for mac_result_collector with K_TILES=4, FIFO_DEPTH=4, STALL_MARGIN=2.
module tb_mac_result_collector;
  logic        clk;
  logic        reset;
  logic [31:0] sum_in;
  logic [7:0]  addr_i_in;
  logic [7:0]  addr_k_in;
  logic        val_in;
  logic        stall_out;
  logic        overflow;
  logic        tag_err;

  int errors = 0;
  int checks = 0;

  mac_result_collector_if #(.ACC_W(34), .AIW(8), .AKW(8)) rif ();

  mac_result_collector #(
    .DATA_WIDTH      (8),
    .ADDRESS_WIDTH_I (8),
    .ADDRESS_WIDTH_K (8),
    .K_TILES         (4),
    .FIFO_DEPTH      (4),
    .STALL_MARGIN    (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sum_in    (sum_in),
    .addr_i_in (addr_i_in),
    .addr_k_in (addr_k_in),
    .val_in    (val_in),
    .res       (rif),
    .stall_out (stall_out),
    .overflow  (overflow),
    .tag_err   (tag_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One valid beat; returns #1 after the edge that accepted it.
  task automatic beat(input logic [31:0] s, input logic [7:0] i, input logic [7:0] k);
    sum_in    = s;
    addr_i_in = i;
    addr_k_in = k;
    val_in    = 1'b1;
    @(posedge clk);
    #1;
    val_in    = 1'b0;
  endtask

  task automatic idle(input int n);
    val_in = 1'b0;
    sum_in = 32'hDEAD;
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic element(input logic [31:0] s, input logic [7:0] i, input logic [7:0] k);
    for (int j = 0; j < 4; j++) beat(s, i, k);
  endtask

  task automatic chk_head(input string tag, input logic [33:0] d, input logic [7:0] i, input logic [7:0] k);
    chk({tag, "_val"}, 64'(rif.res_val), 64'd1);
    chk({tag, "_data"}, 64'(rif.res_data), 64'(d));
    chk({tag, "_addr_i"}, 64'(rif.res_addr_i), 64'(i));
    chk({tag, "_addr_k"}, 64'(rif.res_addr_k), 64'(k));
  endtask

  initial begin
    reset = 1'b1;
    val_in = 1'b0;
    sum_in = '0;
    addr_i_in = '0;
    addr_k_in = '0;
    rif.res_rdy = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_val", 64'(rif.res_val), 64'd0);
    chk("rst_data", 64'(rif.res_data), 64'd0);
    chk("rst_stall", 64'(stall_out), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_tagerr", 64'(tag_err), 64'd0);
    reset = 1'b0;
    idle(1);

    // Back-to-back tiles 1+2+3+4 at (3,5).
    beat(32'd1, 8'd3, 8'd5);
    beat(32'd2, 8'd3, 8'd5);
    beat(32'd3, 8'd3, 8'd5);
    chk("t1_not_yet", 64'(rif.res_val), 64'd0);
    beat(32'd4, 8'd3, 8'd5);
    chk_head("t1", 34'd10, 8'd3, 8'd5);
    chk("t1_tagerr", 64'(tag_err), 64'd0);
    idle(1);
    chk("t1_popped", 64'(rif.res_val), 64'd0);

    // Same element with gaps carrying garbage on sum_in.
    beat(32'd1, 8'd3, 8'd5); idle(2);
    beat(32'd2, 8'd3, 8'd5); idle(2);
    beat(32'd3, 8'd3, 8'd5); idle(2);
    beat(32'd4, 8'd3, 8'd5);
    chk_head("t2", 34'd10, 8'd3, 8'd5);
    idle(1);

    // Tag change mid-element restarts accumulation at (2,2).
    beat(32'd5, 8'd1, 8'd1);
    beat(32'd6, 8'd1, 8'd1);
    beat(32'd1, 8'd2, 8'd2);
    chk("t3_tagerr", 64'(tag_err), 64'd1);
    chk("t3_no_11", 64'(rif.res_val), 64'd0);
    beat(32'd1, 8'd2, 8'd2);
    beat(32'd1, 8'd2, 8'd2);
    chk("t3_not_yet", 64'(rif.res_val), 64'd0);
    beat(32'd1, 8'd2, 8'd2);
    chk_head("t3", 34'd4, 8'd2, 8'd2);
    idle(1);
    chk("t3_single", 64'(rif.res_val), 64'd0);

    // Backpressure: five elements of n*4 into a 4-deep FIFO.
    rif.res_rdy = 1'b0;
    element(32'd1, 8'd1, 8'd1);
    chk("t4_stall1", 64'(stall_out), 64'd0);
    element(32'd2, 8'd2, 8'd2);
    chk("t4_stall2", 64'(stall_out), 64'd0);
    element(32'd3, 8'd3, 8'd3);
    chk("t4_stall3", 64'(stall_out), 64'd1);
    chk_head("t4_hold", 34'd4, 8'd1, 8'd1);
    element(32'd4, 8'd4, 8'd4);
    chk("t4_stall4", 64'(stall_out), 64'd1);
    chk("t4_ovf4", 64'(overflow), 64'd0);
    element(32'd5, 8'd5, 8'd5);
    chk("t4_ovf5", 64'(overflow), 64'd1);
    rif.res_rdy = 1'b1;
    chk_head("t4_d0", 34'd4, 8'd1, 8'd1);
    idle(1);
    chk_head("t4_d1", 34'd8, 8'd2, 8'd2);
    idle(1);
    chk_head("t4_d2", 34'd12, 8'd3, 8'd3);
    idle(1);
    chk_head("t4_d3", 34'd16, 8'd4, 8'd4);
    idle(1);
    chk("t4_empty", 64'(rif.res_val), 64'd0);
    chk("t4_stall_clr", 64'(stall_out), 64'd0);
    chk("t4_ovf_sticky", 64'(overflow), 64'd1);

    // Widest possible sum: 4 x 0xFFFF_FFFF.
    element(32'hFFFF_FFFF, 8'd9, 8'd9);
    chk_head("t5", 34'h3_FFFF_FFFC, 8'd9, 8'd9);
    idle(1);

    // Reset mid-element with a beat presented during reset.
    beat(32'd2, 8'd7, 8'd7);
    beat(32'd2, 8'd7, 8'd7);
    reset = 1'b1;
    beat(32'd9, 8'd7, 8'd7);
    chk("t6_rst_val", 64'(rif.res_val), 64'd0);
    chk("t6_rst_data", 64'(rif.res_data), 64'd0);
    chk("t6_rst_addr", 64'({rif.res_addr_i, rif.res_addr_k}), 64'd0);
    chk("t6_rst_stall", 64'(stall_out), 64'd0);
    chk("t6_rst_ovf", 64'(overflow), 64'd0);
    chk("t6_rst_tagerr", 64'(tag_err), 64'd0);
    reset = 1'b0;
    element(32'd2, 8'd7, 8'd7);
    chk_head("t6", 34'd8, 8'd7, 8'd7);
    chk("t6_tagerr", 64'(tag_err), 64'd0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
